// File: rtl/dft_accumulation.sv
// Windowed multi-bin DFT accumulator: 3-stage pipeline, per-bin complex MAC.
// Optional DFT_ACCUM_ROUND_EN: round-half-up on both scaling shifts.
module dft_accumulation #(
  parameter int IQ_WIDTH           = 16,
  parameter int WINDOW_WIDTH       = 16,
  parameter int ACCUM_WIDTH        = 48,
  parameter int NUM_BINS           = 24,
  parameter int OSC_WIDTH          = 27,
  parameter int SAMPLE_COUNT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          sample_valid_i,
  input  logic                          last_sample_i,
  input  logic signed [IQ_WIDTH-1:0]    i_sample_i,
  input  logic signed [IQ_WIDTH-1:0]    q_sample_i,
  input  logic signed [WINDOW_WIDTH-1:0] window_coeff_i,
  input  logic signed [OSC_WIDTH-1:0]   W_real_i [NUM_BINS],
  input  logic signed [OSC_WIDTH-1:0]   W_imag_i [NUM_BINS],
  output logic signed [ACCUM_WIDTH-1:0] A_real_o [NUM_BINS],
  output logic signed [ACCUM_WIDTH-1:0] A_imag_o [NUM_BINS],
  output logic                          valid_o,
  output logic                          busy_o
);

  localparam int XW  = IQ_WIDTH + 1;
  localparam int P1W = IQ_WIDTH + WINDOW_WIDTH;
  localparam int P2W = XW + OSC_WIDTH + 1;
  localparam int PRW = P2W - OSC_WIDTH + 1;
  localparam int SCW = SAMPLE_COUNT_WIDTH;

`ifdef DFT_ACCUM_ROUND_EN
  localparam logic signed [P1W-1:0] RND1 = P1W'(1) << (WINDOW_WIDTH-2);
  localparam logic signed [P2W-1:0] RND2 = P2W'(1) << (OSC_WIDTH-2);
`else
  localparam logic signed [P1W-1:0] RND1 = '0;
  localparam logic signed [P2W-1:0] RND2 = '0;
`endif

  localparam logic [SCW-1:0] CNT_PRE = {{(SCW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic [SCW-1:0] cnt_q;
  logic           accept, is_last;
  logic           v1_q, l1_q, v2_q, l2_q, l3_q;

  logic signed [XW-1:0]        xr_d, xi_d, xr_q, xi_q;
  logic signed [OSC_WIDTH-1:0] wr_q [NUM_BINS];
  logic signed [OSC_WIDTH-1:0] wi_q [NUM_BINS];
  logic signed [PRW-1:0]       pr_d [NUM_BINS];
  logic signed [PRW-1:0]       pi_d [NUM_BINS];
  logic signed [PRW-1:0]       pr_q [NUM_BINS];
  logic signed [PRW-1:0]       pi_q [NUM_BINS];

  assign accept  = (state_q == ACCUM) && sample_valid_i && !start_i;
  assign is_last = last_sample_i || (cnt_q == CNT_PRE);

  always_comb begin
    xr_d = XW'((P1W'(i_sample_i) * P1W'(window_coeff_i) + RND1)
               >>> (WINDOW_WIDTH-1));
    xi_d = XW'((P1W'(q_sample_i) * P1W'(window_coeff_i) + RND1)
               >>> (WINDOW_WIDTH-1));
  end

  // Full-precision complex product, scaled back by the oscillator Q format
  always_comb begin
    for (int k = 0; k < NUM_BINS; k++) begin
      pr_d[k] = PRW'((P2W'(xr_q) * P2W'(wr_q[k])
                    - P2W'(xi_q) * P2W'(wi_q[k]) + RND2)
                    >>> (OSC_WIDTH-1));
      pi_d[k] = PRW'((P2W'(xr_q) * P2W'(wi_q[k])
                    + P2W'(xi_q) * P2W'(wr_q[k]) + RND2)
                    >>> (OSC_WIDTH-1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      v1_q  <= 1'b0;
      l1_q  <= 1'b0;
      v2_q  <= 1'b0;
      l2_q  <= 1'b0;
      l3_q  <= 1'b0;
      xr_q  <= '0;
      xi_q  <= '0;
      for (int k = 0; k < NUM_BINS; k++) begin
        wr_q[k]     <= '0;
        wi_q[k]     <= '0;
        pr_q[k]     <= '0;
        pi_q[k]     <= '0;
        A_real_o[k] <= '0;
        A_imag_o[k] <= '0;
      end
    end else if (start_i) begin
      cnt_q <= '0;
      v1_q  <= 1'b0;
      l1_q  <= 1'b0;
      v2_q  <= 1'b0;
      l2_q  <= 1'b0;
      l3_q  <= 1'b0;
      for (int k = 0; k < NUM_BINS; k++) begin
        A_real_o[k] <= '0;
        A_imag_o[k] <= '0;
      end
    end else begin
      v1_q <= accept;
      l1_q <= accept && is_last;
      v2_q <= v1_q;
      l2_q <= l1_q;
      l3_q <= l2_q;
      if (accept) begin
        cnt_q <= cnt_q + 1'b1;
        xr_q  <= xr_d;
        xi_q  <= xi_d;
        for (int k = 0; k < NUM_BINS; k++) begin
          wr_q[k] <= W_real_i[k];
          wi_q[k] <= W_imag_i[k];
        end
      end
      if (v1_q) begin
        for (int k = 0; k < NUM_BINS; k++) begin
          pr_q[k] <= pr_d[k];
          pi_q[k] <= pi_d[k];
        end
      end
      if (v2_q) begin
        for (int k = 0; k < NUM_BINS; k++) begin
          A_real_o[k] <= A_real_o[k] + ACCUM_WIDTH'(pr_q[k]);
          A_imag_o[k] <= A_imag_o[k] + ACCUM_WIDTH'(pi_q[k]);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE:  ;
      ACCUM: begin
        busy_o = 1'b1;
        if (accept && is_last) state_d = DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (l3_q) state_d = DONE;
      end
      DONE:  valid_o = 1'b1;
      default: state_d = IDLE;
    endcase
    if (start_i) state_d = ACCUM;
  end

endmodule

// File: tb/tb_dft_accumulation.sv
// Directed self-checking bench for dft_accumulation.
// Honors DFT_ACCUM_ROUND_EN for expected values.
module tb_dft_accumulation;

  localparam int NB = 24;

`ifdef DFT_ACCUM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  localparam logic signed [47:0] DC_EXP =
    RND ? 48'sh200000 : 48'sh1FFF00;
  localparam logic signed [47:0] QD_EXP = -48'sd2097152;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, sv, last;
  logic signed [15:0] iv, qv, wv;
  logic signed [26:0] wr_a [NB];
  logic signed [26:0] wi_a [NB];
  logic signed [47:0] a_re [NB];
  logic signed [47:0] a_im [NB];
  logic valid, busy;

  int n_cmp = 0;
  int n_err = 0;
  bit busy_ok;

  dft_accumulation dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .sample_valid_i(sv), .last_sample_i(last),
    .i_sample_i(iv), .q_sample_i(qv),
    .window_coeff_i(wv),
    .W_real_i(wr_a), .W_imag_i(wi_a),
    .A_real_o(a_re), .A_imag_o(a_im),
    .valid_o(valid), .busy_o(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_osc(input logic signed [26:0] wr,
                         input logic signed [26:0] wi);
    for (int k = 0; k < NB; k++) begin
      wr_a[k] = wr;
      wi_a[k] = wi;
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic signed [15:0] i,
                      input logic signed [15:0] q,
                      input logic signed [15:0] w,
                      input bit lst);
    iv = i; qv = q; wv = w;
    sv = 1'b1; last = lst;
    tick();
    sv = 1'b0; last = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit gaps,
                           input bit with_last,
                           input logic signed [15:0] i,
                           input logic signed [15:0] q,
                           input logic signed [26:0] wr,
                           input logic signed [26:0] wi);
    set_osc(wr, wi);
    busy_ok = 1'b1;
    for (int s = 0; s < n; s++) begin
      if (gaps && s > 0) begin
        tick();
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
      send(i, q, 16'sh7FFF, with_last && (s == n-1));
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    bit zero;
    rst = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b want 0", valid);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    zero = 1'b1;
    for (int k = 0; k < NB; k++)
      if (a_re[k] !== '0 || a_im[k] !== '0) zero = 1'b0;
    n_cmp++;
    if (!zero) begin
      n_err++; $display("FAIL reset_acc: got nonzero want all 0");
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b want 0/0",
               busy, valid);
    end
  endtask

  task automatic test_dc;
    do_start();
    n_cmp++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL dc_start: got busy=%b valid=%b want 1/0",
               busy, valid);
    end
    run_frame(256, 1'b0, 1'b1, 16'sh4000, 16'sh0000,
              27'sh2000000, 27'sh0);
    n_cmp++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL dc_drain: got busy=%b valid=%b want 1/0",
               busy, valid);
    end
    tick();
    tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++; $display("FAIL dc_valid_early: got %b want 0", valid);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL dc_valid_lat3: got valid=%b busy=%b want 1/0",
               valid, busy);
    end
    n_cmp++;
    if (a_re[0] !== DC_EXP) begin
      n_err++; $display("FAIL dc_re0: got %h want %h", a_re[0], DC_EXP);
    end
    n_cmp++;
    if (a_im[0] !== '0) begin
      n_err++; $display("FAIL dc_im0: got %h want 0", a_im[0]);
    end
    n_cmp++;
    if (a_re[NB-1] !== DC_EXP) begin
      n_err++;
      $display("FAIL dc_re_last_bin: got %h want %h", a_re[NB-1], DC_EXP);
    end
  endtask

  task automatic test_done_hold;
    bit held;
    held = 1'b1;
    set_osc(27'sh1000000, 27'sh1000000);
    for (int c = 0; c < 6; c++) begin
      send(16'sh1234, 16'sh4321, 16'sh7FFF, 1'b1);
      if (valid !== 1'b1 || a_re[0] !== DC_EXP || a_im[0] !== '0)
        held = 1'b0;
    end
    n_cmp++;
    if (!held) begin
      n_err++;
      $display("FAIL done_hold: got valid=%b re=%h want 1/%h",
               valid, a_re[0], DC_EXP);
    end
  endtask

  task automatic test_quad;
    do_start();
    run_frame(256, 1'b0, 1'b1, 16'sh0000, 16'sh4000,
              27'sh0, 27'sh2000000);
    repeat (3) tick();
    n_cmp++;
    if (valid !== 1'b1) begin
      n_err++; $display("FAIL quad_valid: got %b want 1", valid);
    end
    n_cmp++;
    if (a_re[0] !== QD_EXP) begin
      n_err++; $display("FAIL quad_re0: got %h want %h", a_re[0], QD_EXP);
    end
    n_cmp++;
    if (a_im[0] !== '0) begin
      n_err++; $display("FAIL quad_im0: got %h want 0", a_im[0]);
    end
  endtask

  task automatic test_gaps;
    do_start();
    run_frame(256, 1'b1, 1'b1, 16'sh4000, 16'sh0000,
              27'sh2000000, 27'sh0);
    n_cmp++;
    if (!busy_ok) begin
      n_err++; $display("FAIL gaps_busy: got busy low want 1 throughout");
    end
    repeat (3) tick();
    n_cmp++;
    if (valid !== 1'b1 || a_re[0] !== DC_EXP) begin
      n_err++;
      $display("FAIL gaps_result: got valid=%b re=%h want 1/%h",
               valid, a_re[0], DC_EXP);
    end
  endtask

  task automatic test_restart;
    do_start();
    run_frame(100, 1'b0, 1'b0, 16'sh4000, 16'sh0000,
              27'sh2000000, 27'sh0);
    do_start();
    n_cmp++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL restart_state: got busy=%b valid=%b want 1/0",
               busy, valid);
    end
    repeat (3) tick();
    n_cmp++;
    if (a_re[0] !== '0) begin
      n_err++; $display("FAIL restart_flush: got %h want 0", a_re[0]);
    end
    run_frame(256, 1'b0, 1'b1, 16'sh4000, 16'sh0000,
              27'sh2000000, 27'sh0);
    repeat (3) tick();
    n_cmp++;
    if (valid !== 1'b1 || a_re[0] !== DC_EXP) begin
      n_err++;
      $display("FAIL restart_result: got valid=%b re=%h want 1/%h",
               valid, a_re[0], DC_EXP);
    end
  endtask

  task automatic test_start_with_sample;
    do_start();
    set_osc(27'sh2000000, 27'sh0);
    iv = 16'sh4000; qv = 16'sh0; wv = 16'sh7FFF;
    start = 1'b1; sv = 1'b1;
    tick();
    start = 1'b0; sv = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (a_re[0] !== '0) begin
      n_err++; $display("FAIL start_sample_drop: got %h want 0", a_re[0]);
    end
    run_frame(256, 1'b0, 1'b1, 16'sh4000, 16'sh0000,
              27'sh2000000, 27'sh0);
    repeat (3) tick();
    n_cmp++;
    if (valid !== 1'b1 || a_re[0] !== DC_EXP) begin
      n_err++;
      $display("FAIL start_sample_result: got valid=%b re=%h want 1/%h",
               valid, a_re[0], DC_EXP);
    end
  endtask

  task automatic test_drain_abort;
    bit never;
    do_start();
    run_frame(10, 1'b0, 1'b1, 16'sh4000, 16'sh0000,
              27'sh2000000, 27'sh0);
    do_start();
    never = (valid === 1'b0);
    repeat (5) begin
      tick();
      if (valid !== 1'b0) never = 1'b0;
    end
    n_cmp++;
    if (!never || busy !== 1'b1) begin
      n_err++;
      $display("FAIL drain_abort: got valid_seen=%b busy=%b want 0/1",
               !never, busy);
    end
    n_cmp++;
    if (a_re[0] !== '0) begin
      n_err++; $display("FAIL drain_abort_acc: got %h want 0", a_re[0]);
    end
  endtask

  task automatic test_reset_midframe;
    bit never;
    do_start();
    run_frame(20, 1'b0, 1'b0, 16'sh4000, 16'sh0000,
              27'sh2000000, 27'sh0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0 || a_re[0] !== '0) begin
      n_err++;
      $display("FAIL midframe_reset: got busy=%b valid=%b re=%h want 0/0/0",
               busy, valid, a_re[0]);
    end
    never = 1'b1;
    repeat (5) begin
      tick();
      if (valid !== 1'b0 || a_re[0] !== '0) never = 1'b0;
    end
    n_cmp++;
    if (!never) begin
      n_err++; $display("FAIL midframe_no_valid: got pulse want none");
    end
  endtask

  task automatic test_all_bins;
    longint mre [NB];
    longint mim [NB];
    longint xr, xi, p, d;
    longint r1, r2;
    logic signed [15:0] i, q, w;
    r1 = RND ? 64'sd16384 : 64'sd0;
    r2 = RND ? 64'sd33554432 : 64'sd0;
    for (int k = 0; k < NB; k++) begin
      mre[k] = 0;
      mim[k] = 0;
    end
    do_start();
    for (int s = 0; s < 256; s++) begin
      i = 16'($urandom);
      q = 16'($urandom);
      w = 16'($urandom);
      xr = (longint'(i) * longint'(w) + r1) >>> 15;
      xi = (longint'(q) * longint'(w) + r1) >>> 15;
      for (int k = 0; k < NB; k++) begin
        wr_a[k] = 27'($urandom);
        wi_a[k] = 27'($urandom);
        p = (xr * longint'(wr_a[k]) - xi * longint'(wi_a[k]) + r2) >>> 26;
        mre[k] += p;
        p = (xr * longint'(wi_a[k]) + xi * longint'(wr_a[k]) + r2) >>> 26;
        mim[k] += p;
      end
      send(i, q, w, s == 255);
    end
    repeat (3) tick();
    n_cmp++;
    if (valid !== 1'b1) begin
      n_err++; $display("FAIL bins_valid: got %b want 1", valid);
    end
    for (int k = 0; k < NB; k++) begin
      d = longint'(a_re[k]) - mre[k];
      n_cmp++;
      if (d > 100 || d < -100) begin
        n_err++;
        $display("FAIL bin%0d_re: got %0d want %0d", k, a_re[k], mre[k]);
      end
      d = longint'(a_im[k]) - mim[k];
      n_cmp++;
      if (d > 100 || d < -100) begin
        n_err++;
        $display("FAIL bin%0d_im: got %0d want %0d", k, a_im[k], mim[k]);
      end
    end
  endtask

  task automatic test_count_limit;
    longint exp_re;
    exp_re = 65535 * (RND ? 64'sd8192 : 64'sd8191);
    do_start();
    run_frame(65535, 1'b0, 1'b0, 16'sh4000, 16'sh0000,
              27'sh2000000, 27'sh0);
    tick();
    tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++; $display("FAIL cnt_valid_early: got %b want 0", valid);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b1) begin
      n_err++; $display("FAIL cnt_limit_last: got valid=%b want 1", valid);
    end
    n_cmp++;
    if (longint'(a_re[0]) != exp_re) begin
      n_err++;
      $display("FAIL cnt_limit_sum: got %0d want %0d", a_re[0], exp_re);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sv = 1'b0; last = 1'b0;
    iv = '0; qv = '0; wv = '0;
    set_osc(27'sh0, 27'sh0);
    test_reset();
    test_dc();
    test_done_hold();
    test_quad();
    test_gaps();
    test_restart();
    test_start_with_sample();
    test_drain_abort();
    test_reset_midframe();
    test_all_bins();
    test_count_limit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dft_accumulation.md
DFT_ACCUMULATION -- requirements
Module: dft_accumulation

Interface
REQ-001 SHALL have parameter IQ_WIDTH, default 16: signed I/Q sample width.
REQ-002 SHALL have parameter WINDOW_WIDTH, default 16: signed window coefficient width, Q1.(WINDOW_WIDTH-1).
REQ-003 SHALL have parameter ACCUM_WIDTH, default 48: signed accumulator and output width.
REQ-004 SHALL have parameter NUM_BINS, default 24: number of DFT bins.
REQ-005 SHALL have parameter OSC_WIDTH, default 27: signed oscillator width, Q1.(OSC_WIDTH-1).
REQ-006 SHALL have parameter SAMPLE_COUNT_WIDTH, default 16: internal accepted-sample counter width.
REQ-007 SHALL use one clock and a synchronous, active-high reset.
REQ-008 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-009 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-010 SHALL have port start_i, input, 1 bit: clear accumulators and begin a frame.
REQ-011 SHALL have port sample_valid_i, input, 1 bit: sample and oscillator inputs valid this cycle.
REQ-012 SHALL have port last_sample_i, input, 1 bit: final sample of the frame, qualified by sample_valid_i.
REQ-013 SHALL have ports i_sample_i and q_sample_i, input, IQ_WIDTH bits, signed: complex input sample.
REQ-014 SHALL have port window_coeff_i, input, WINDOW_WIDTH bits, signed: window value for this sample.
REQ-015 SHALL have ports W_real_i[NUM_BINS] and W_imag_i[NUM_BINS], input, OSC_WIDTH bits each, signed: per-bin oscillator value for this sample.
REQ-016 SHALL have ports A_real_o[NUM_BINS] and A_imag_o[NUM_BINS], output, ACCUM_WIDTH bits each, signed: bin results.
REQ-017 SHALL have port valid_o, output, 1 bit: results valid.
REQ-018 SHALL have port busy_o, output, 1 bit: frame in progress.

Function
REQ-019 SHALL implement the states IDLE, ACCUM, DRAIN and DONE. start_i moves the block from any state to ACCUM. An accepted last sample moves ACCUM to DRAIN. DRAIN moves to DONE once the pipeline is empty.
REQ-020 SHALL accept a sample only in ACCUM when sample_valid_i=1. sample_valid_i in other states is ignored. last_sample_i without sample_valid_i is ignored.
REQ-021 SHALL compute the windowed sample xr = (I*w) >>> (WINDOW_WIDTH-1) and xi = (Q*w) >>> (WINDOW_WIDTH-1), held at IQ_WIDTH+1 bits with no saturation.
REQ-022 SHALL, per bin k, compute pr = (xr*Wr[k] - xi*Wi[k]) >>> (OSC_WIDTH-1) and pi = (xr*Wi[k] + xi*Wr[k]) >>> (OSC_WIDTH-1), using full-precision products, then sign-extend to ACCUM_WIDTH.
REQ-023 SHALL accumulate A_real[k] += pr and A_imag[k] += pi with two's-complement wrap on overflow.
REQ-024 SHALL use a fixed pipeline: stage 1 registers the windowed sample, stage 2 registers the products, stage 3 accumulates. The oscillator inputs are sampled in the same cycle as their sample.
REQ-025 SHALL assert valid_o exactly 3 cycles after the edge that accepts the last sample.
REQ-026 SHALL hold valid_o high and A_*_o constant in DONE until the next start_i.
REQ-027 SHALL drive busy_o=1 in ACCUM and DRAIN and 0 otherwise.
REQ-028 SHALL, on start_i, clear all accumulators, drop valid_o, and flush the pipeline on the next edge.
REQ-029 SHALL give start_i priority when start_i and sample_valid_i occur in the same cycle: the sample is discarded.
REQ-030 SHALL give start_i precedence over reporting when it arrives in DRAIN: the in-flight frame is aborted.
REQ-031 SHALL count accepted samples. When the count reaches 2^SAMPLE_COUNT_WIDTH-1, that sample is treated as last.
REQ-032 SHALL drive A_*_o directly from the accumulator registers, so they show running sums during ACCUM.

Reset
REQ-033 SHALL, when rst_i=1 at a rising edge, enter IDLE, zero all accumulators, pipeline registers and the counter, and drive valid_o=0, busy_o=0 and A_*_o=0.
REQ-034 SHALL, when reset occurs mid-frame, discard the frame with no valid_o pulse.

Configuration
REQ-035 SHALL support the macro DFT_ACCUM_ROUND_EN. When defined, both right shifts (REQ-021, REQ-022) add half an LSB before shifting (round half up). When undefined, the shifts truncate (floor).

Verification
REQ-036 SHALL be verified for reset: hold rst_i 5 cycles -> valid_o=0, busy_o=0, all A_*_o=0.
REQ-037 SHALL be verified for DC, bin 0: 256 samples of I=0x4000, Q=0, w=0x7FFF, Wr=0x2000000, Wi=0 -> A_real[0]=0x1FFF00 (truncate) or 0x200000 (DFT_ACCUM_ROUND_EN), A_imag[0]=0, valid_o 3 cycles after last.
REQ-038 SHALL be verified for the quadrature path: 256 samples of I=0, Q=0x4000, w=0x7FFF, Wr=0, Wi=0x2000000, truncate build -> A_real[0]=0xFFFFFFE00000 (-2097152), A_imag[0]=0.
REQ-039 SHALL be verified for gaps: same frame as REQ-037 with sample_valid_i low every other cycle -> identical results, busy_o=1 throughout.
REQ-040 SHALL be verified for restart: start_i after 100 samples, then a full 256-sample frame as REQ-037 -> result equals REQ-037. start_i together with sample_valid_i -> that sample is not counted.
REQ-041 SHALL be verified for all bins: 24 bins with distinct random Wr/Wi, 256 samples -> every bin within 100 LSB of a bit-accurate model.
